// File: rtl/walker_pkg.sv
// Shared definitions for the Wishbone LED walker: register map, CTRL/STATUS field
// positions and the walk state encoding.
package walker_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_ABORT  = 2'd3;

    localparam int unsigned CTRL_MODE_BIT = 0;
    localparam int unsigned CTRL_REPS_LSB = 8;
    localparam int unsigned CTRL_REPS_W   = 8;

    localparam int unsigned STATUS_BUSY_BIT = 31;
    localparam int unsigned STATUS_PASS_LSB = 16;
    localparam int unsigned STATUS_POS_LSB  = 0;

    typedef enum logic [1:0] {IDLE, UP, DOWN} walk_state_e;

endpackage

// File: rtl/walker_step_timer.sv
// Step-period down-counter for the LED walker: each position is held i_div+1 cycles,
// o_step pulses on the last cycle of a hold.
module walker_step_timer #(
    parameter int unsigned DIVW = 24
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_load,
    input  logic            i_en,
    input  logic [DIVW-1:0] i_div,
    output logic            o_step
);

    logic [DIVW-1:0] count;

    assign o_step = i_en && (count == '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_load || o_step) begin
            count <= i_div;
        end else if (i_en) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/wb_led_walker.sv
// Wishbone-slave LED walker: a single lit LED walks across NLEDS outputs, bounce or one-way.
// Define WALKER_ABORT_EN to let a write to address 3 end a walk immediately.
module wb_led_walker
    import walker_pkg::*;
#(
    parameter int unsigned NLEDS = 8,
    parameter int unsigned DIVW  = 24
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cyc,
    input  logic             i_stb,
    input  logic             i_we,
    input  logic [1:0]       i_addr,
    input  logic [31:0]      i_data,
    output logic             o_stall,
    output logic             o_ack,
    output logic [31:0]      o_data,
    output logic [NLEDS-1:0] o_led,
    output logic             o_busy
);

    localparam int unsigned     POSW     = $clog2(NLEDS);
    localparam logic [POSW-1:0] LAST_POS = POSW'(NLEDS - 1);

    walk_state_e            state;
    logic [POSW-1:0]        pos;
    logic [CTRL_REPS_W-1:0] passes;
    logic [CTRL_REPS_W-1:0] reps_q;
    logic                   mode_q;
    logic [DIVW-1:0]        div_q;
    logic [DIVW-1:0]        reload_div;
    logic                   busy, acc, wr_ctrl, wr_div, step;
    logic [31:0]            rdata;
    logic                   unused_data;

    assign busy    = (state != IDLE);
    assign o_busy  = busy;
    assign o_stall = busy && i_we && (i_addr == ADDR_CTRL);
    assign acc     = i_cyc && i_stb && !o_stall;
    assign wr_ctrl = acc && i_we && (i_addr == ADDR_CTRL);
    assign wr_div  = acc && i_we && (i_addr == ADDR_DIV);

    // A DIV write coinciding with a reload edge already governs the position that follows.
    assign reload_div  = wr_div ? i_data[DIVW-1:0] : div_q;
    assign unused_data = ^{i_data[31:16], i_data[7:1]};

    walker_step_timer #(
        .DIVW (DIVW)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (wr_ctrl),
        .i_en      (busy),
        .i_div     (reload_div),
        .o_step    (step)
    );

    always_comb begin
        rdata = '0;
        case (i_addr)
            ADDR_CTRL: begin
                rdata[CTRL_MODE_BIT]                 = mode_q;
                rdata[CTRL_REPS_LSB +: CTRL_REPS_W]  = reps_q;
            end
            ADDR_DIV:    rdata[DIVW-1:0] = div_q;
            ADDR_STATUS: begin
                rdata[STATUS_BUSY_BIT]                = busy;
                rdata[STATUS_PASS_LSB +: CTRL_REPS_W] = passes;
                rdata[STATUS_POS_LSB +: POSW]         = pos;
            end
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_q <= 1'b0;
            reps_q <= '0;
            div_q  <= '0;
            o_ack  <= 1'b0;
            o_data <= '0;
        end else begin
            if (wr_ctrl) begin
                mode_q <= i_data[CTRL_MODE_BIT];
                reps_q <= i_data[CTRL_REPS_LSB +: CTRL_REPS_W];
            end
            if (wr_div) begin
                div_q <= i_data[DIVW-1:0];
            end
            o_ack  <= acc;
            o_data <= (acc && !i_we) ? rdata : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            pos    <= '0;
            passes <= '0;
            o_led  <= '0;
        end else if (wr_ctrl) begin
            state  <= UP;
            pos    <= '0;
            passes <= i_data[CTRL_REPS_LSB +: CTRL_REPS_W];
            o_led  <= NLEDS'(1);
`ifdef WALKER_ABORT_EN
        end else if (acc && i_we && (i_addr == ADDR_ABORT)) begin
            state  <= IDLE;
            pos    <= '0;
            passes <= '0;
            o_led  <= '0;
`endif
        end else if (step) begin
            unique case (state)
                UP: begin
                    if (pos != LAST_POS) begin
                        pos   <= pos + 1'b1;
                        o_led <= o_led << 1;
                    end else if (mode_q) begin
                        state <= DOWN;
                        pos   <= pos - 1'b1;
                        o_led <= o_led >> 1;
                    end else if (passes == '0) begin
                        state <= IDLE;
                        pos   <= '0;
                        o_led <= '0;
                    end else begin
                        passes <= passes - 1'b1;
                        pos    <= '0;
                        o_led  <= NLEDS'(1);
                    end
                end
                DOWN: begin
                    if (pos != '0) begin
                        pos   <= pos - 1'b1;
                        o_led <= o_led >> 1;
                    end else if (passes == '0) begin
                        state <= IDLE;
                        o_led <= '0;
                    end else begin
                        // Endpoint 0 was the last position of this pass; resume at 1.
                        passes <= passes - 1'b1;
                        state  <= UP;
                        pos    <= POSW'(1);
                        o_led  <= NLEDS'(2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_led_walker.sv
// Self-checking bench for wb_led_walker: table-driven walks with a bus scoreboard plus
// hand-written stall, DIV-change, address-3 and reset sequences.
`timescale 1ns/1ps
module tb_wb_led_walker;

    localparam int NLEDS = 8;
    localparam int DIVW  = 24;

    logic             i_clk     = 1'b0;
    logic             i_reset_n = 1'b1;
    logic             i_cyc     = 1'b0;
    logic             i_stb     = 1'b0;
    logic             i_we      = 1'b0;
    logic [1:0]       i_addr    = 2'd0;
    logic [31:0]      i_data    = 32'd0;
    logic             o_stall, o_ack, o_busy;
    logic [31:0]      o_data;
    logic [NLEDS-1:0] o_led;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        int          due;
    } sb_item_t;
    sb_item_t sb[$];

    logic [NLEDS-1:0] exp_led[$];

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] div;
        logic [31:0] div_rd;
        logic [31:0] ctrl_rd;
        int          busy;
    } vec_t;
    vec_t vecs[4];

    wb_led_walker #(
        .NLEDS (NLEDS),
        .DIVW  (DIVW)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_cyc     (i_cyc),
        .i_stb     (i_stb),
        .i_we      (i_we),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .o_stall   (o_stall),
        .o_ack     (o_ack),
        .o_data    (o_data),
        .o_led     (o_led),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Every ack must match the oldest accepted access and land in the cycle after acceptance.
    always @(negedge i_clk) begin
        sb_item_t it;
        if (i_reset_n && o_ack) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'(o_ack), 32'd0);
            end else begin
                it = sb.pop_front();
                check("ack_latency", 32'(cyc_n), 32'(it.due));
                if (it.is_read) check("rd_data", o_data, it.data);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic bus(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, output int stalls);
        sb_item_t it;
        bit       done = 0;
        stalls = 0;
        i_cyc  = 1'b1;
        i_stb  = 1'b1;
        i_we   = we;
        i_addr = addr;
        i_data = wdata;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge i_clk);
            if (o_stall) stalls++;
            else done = 1;
            @(posedge i_clk);
        end
        #1;
        i_cyc = 1'b0;
        i_stb = 1'b0;
        i_we  = 1'b0;
        if (!done) begin
            check("bus_timeout", 32'(done), 32'd1);
        end else begin
            it.is_read = !we;
            it.data    = exp_rd;
            it.due     = cyc_n;
            sb.push_back(it);
        end
    endtask

    task automatic push_pos(input int i, input int hold, input int skip, inout int n);
        logic [NLEDS-1:0] one = 1;
        for (int h = 0; h < hold; h++) begin
            if (n >= skip) exp_led.push_back(one << i);
            n++;
        end
    endtask

    task automatic build_walk(input bit mode, input int reps, input int hold, input int skip);
        int n = 0;
        exp_led.delete();
        for (int p = 0; p <= reps; p++) begin
            if (mode) begin
                for (int i = (p == 0) ? 0 : 1; i < NLEDS; i++) push_pos(i, hold, skip, n);
                for (int i = NLEDS - 2; i >= 0; i--) push_pos(i, hold, skip, n);
            end else begin
                for (int i = 0; i < NLEDS; i++) push_pos(i, hold, skip, n);
            end
        end
    endtask

    // Compares o_led each cycle against exp_led until busy drops.
    task automatic check_walk(input string name, input int exp_busy);
        int busy_cnt = 0;
        int mism     = 0;
        bit ended    = 0;
        for (int k = 0; k < 4000 && !ended; k++) begin
            @(negedge i_clk);
            if (!o_busy) begin
                ended = 1;
            end else begin
                if (busy_cnt >= exp_led.size() || o_led !== exp_led[busy_cnt]) mism++;
                busy_cnt++;
            end
        end
        check({name, "_ended"}, 32'(ended), 32'd1);
        check({name, "_seq"}, 32'(mism), 32'd0);
        check({name, "_busy"}, 32'(busy_cnt), 32'(exp_busy));
        check({name, "_led_off"}, 32'(o_led), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int st;
        int n;
        int tail;

        #1 i_reset_n = 1'b0;
        #1;
        check("rst_led", 32'(o_led), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        bus(1'b0, 2'd2, 32'd0, 32'h0000_0000, st);
        bus(1'b0, 2'd1, 32'd0, 32'h0000_0000, st);

        vecs[0] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 15};
        vecs[1] = '{32'h0000_0000, 32'hFF00_0002, 32'h0000_0002, 32'h0000_0000, 24};
        vecs[2] = '{32'hA5A5_01FE, 32'h0000_0001, 32'h0000_0001, 32'h0000_0100, 32};
        vecs[3] = '{32'h0000_0101, 32'h0000_0003, 32'h0000_0003, 32'h0000_0101, 116};
        for (int v = 0; v < 4; v++) begin
            bus(1'b1, 2'd1, vecs[v].div, 32'd0, st);
            bus(1'b0, 2'd1, 32'd0, vecs[v].div_rd, st);
            build_walk(vecs[v].ctrl[0], int'(vecs[v].ctrl[15:8]), int'(vecs[v].div_rd) + 1, 0);
            bus(1'b1, 2'd0, vecs[v].ctrl, 32'd0, st);
            check_walk($sformatf("vec%0d", v), vecs[v].busy);
            bus(1'b0, 2'd0, 32'd0, vecs[v].ctrl_rd, st);
            bus(1'b0, 2'd2, 32'd0, 32'h0000_0000, st);
        end

        // Bounce with REPS=2, DIV=0: STATUS sampled at walk steps 0, 10, 19 and 34.
        bus(1'b1, 2'd1, 32'd0, 32'd0, st);
        bus(1'b1, 2'd0, 32'h0000_0201, 32'd0, st);
        bus(1'b0, 2'd2, 32'd0, 32'h8002_0000, st);
        check("status_rd_stall", 32'(st), 32'd0);
        repeat (9) @(posedge i_clk);
        #1;
        bus(1'b0, 2'd2, 32'd0, 32'h8002_0004, st);
        repeat (8) @(posedge i_clk);
        #1;
        bus(1'b0, 2'd2, 32'd0, 32'h8001_0005, st);
        repeat (14) @(posedge i_clk);
        #1;
        bus(1'b0, 2'd2, 32'd0, 32'h8000_0006, st);
        check("status_rd_stall_late", 32'(st), 32'd0);
        tail = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (!o_busy) break;
            tail++;
        end
        check("status_walk_tail", 32'(tail), 32'd8);
        @(posedge i_clk);
        #1;
        bus(1'b0, 2'd0, 32'd0, 32'h0000_0201, st);

        // CTRL write while busy stalls for the whole walk, then restarts from position 0.
        bus(1'b1, 2'd0, 32'h0000_0001, 32'd0, st);
        bus(1'b1, 2'd0, 32'h0000_0001, 32'd0, st);
        check("ctrl_stall_cycles", 32'(st), 32'd15);
        build_walk(1'b1, 0, 1, 0);
        check_walk("restart", 15);

        // DIV 0 -> 5 during the first position of a one-way walk.
        bus(1'b1, 2'd0, 32'h0000_0000, 32'd0, st);
        bus(1'b1, 2'd1, 32'd5, 32'd0, st);
        check("div_wr_stall", 32'(st), 32'd0);
        exp_led.delete();
        n = 0;
        for (int i = 1; i < NLEDS; i++) push_pos(i, 6, 0, n);
        check_walk("div_change", 42);
        bus(1'b0, 2'd1, 32'd0, 32'd5, st);

        bus(1'b1, 2'd1, 32'd0, 32'd0, st);
        bus(1'b1, 2'd0, 32'h0000_0001, 32'd0, st);
        bus(1'b1, 2'd3, 32'hFFFF_FFFF, 32'd0, st);
        check("addr3_wr_stall", 32'(st), 32'd0);
`ifdef WALKER_ABORT_EN
        check("abort_led", 32'(o_led), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        bus(1'b0, 2'd2, 32'd0, 32'h0000_0000, st);
`else
        build_walk(1'b1, 0, 1, 1);
        check_walk("addr3_ignored", 14);
`endif
        bus(1'b0, 2'd3, 32'd0, 32'h0000_0000, st);

        // Asynchronous reset in the middle of a walk, away from any clock edge.
        bus(1'b1, 2'd1, 32'd3, 32'd0, st);
        bus(1'b1, 2'd0, 32'h0000_0101, 32'd0, st);
        repeat (10) @(posedge i_clk);
        #3;
        i_reset_n = 1'b0;
        #1;
        check("rst_mid_led", 32'(o_led), 32'd0);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        bus(1'b0, 2'd1, 32'd0, 32'd0, st);
        bus(1'b1, 2'd0, 32'h0000_0001, 32'd0, st);
        build_walk(1'b1, 0, 1, 0);
        check_walk("post_reset", 15);

        repeat (2) @(posedge i_clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_led_walker.md
Name: wb_led_walker

Overview:
Parametrised Wishbone-slave LED walker, successor to the fixed 6-LED request walker. A host write starts a walk of one lit LED across NLEDS outputs, in bounce or one-way mode. Each position is held for a programmable number of cycles, and the walk repeats a programmable number of passes. It sits on the peripheral bus beside the other tutorial slaves and drives board LEDs.

Parameters:
NLEDS, 8, number of LED outputs; legal range 2..32.
DIVW, 24, width of the step-period divider register; legal range 1..31.

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_cyc  in  1  Wishbone cycle
i_stb  in  1  Wishbone strobe
i_we  in  1  Wishbone write enable
i_addr  in  2  register word address
i_data  in  32  write data
o_stall  out  1  Wishbone stall
o_ack  out  1  Wishbone ack
o_data  out  32  read data, valid with o_ack
o_led  out  NLEDS  one-hot LED drive
o_busy  out  1  walk in progress

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, DIV=0, o_led=0, o_ack=0, o_data=0, o_busy=0, timer=0, pass counter=0.
- Register map:
  - 0 CTRL (W): bit0 MODE (1=bounce, 0=one-way), bits[15:8] REPS; total passes = REPS+1.
  - 1 DIV (R/W): [DIVW-1:0]; each position is held DIV+1 cycles.
  - 2 STATUS (R): bit31 busy, [23:16] passes remaining, [4:0] current position.
  - 3: reserved (see optional feature).
- Reads of CTRL return the last written value. Unused bits read 0.
- Stall: o_stall = busy && i_we && (i_addr==0); combinational. All other accesses never stall.
- Ack: o_ack registered, equal to i_cyc && i_stb && !o_stall from the prior cycle. o_data is registered on the same edge.
- A CTRL write accepted at edge t gives, at t+1: state = UP, pos=0, o_led=1, timer=DIV, passes remaining=REPS.
- Timer counts down. When it reaches 0 and a step is due, pos advances and the timer reloads DIV.
- States:
  - IDLE: waiting for a CTRL write.
  - UP: pos increments. At pos==NLEDS-1, bounce mode goes to DOWN; one-way mode wraps pos to 0 and ends the pass.
  - DOWN: pos decrements. Reaching pos==0 ends the pass.
- End of pass: if passes remaining==0, the step goes to IDLE with o_led=0. Otherwise it decrements passes remaining and continues in UP.
  - Bounce: the shared endpoint 0 is shown once only.
  - One-way: position 0 of the next pass is shown.
- Visible positions per walk:
  - bounce: (2*NLEDS-2)*(REPS+1)+1
  - one-way: NLEDS*(REPS+1)
  - busy cycles = positions*(DIV+1).
- o_led is always one-hot while busy and 0 in IDLE. o_busy = (state != IDLE).
- A DIV write while busy is accepted without stall and takes effect at the next timer reload. The current hold is unaffected.
- A CTRL write in the same cycle as the final step: it is stalled because busy is still 1, and is accepted the next cycle from IDLE.
- Reset mid-walk: o_led=0 immediately (asynchronous). Any pending ack is dropped.
- Widths: the position register is $clog2(NLEDS) bits, zero-extended into STATUS. The timer is DIVW bits with no wrap beyond the DIV value.

Optional Feature:
WALKER_ABORT_EN:
- Defined: a write to address 3 (never stalled) forces IDLE and o_led=0 on the next edge. Passes remaining is cleared. Reads of address 3 return 0.
- Undefined: address 3 writes are acked and ignored. No abort logic is synthesised.

Decomposition:
- Package walker_pkg holds:
  - address constants ADDR_CTRL=0, ADDR_DIV=1, ADDR_STATUS=2, ADDR_ABORT=3
  - CTRL field positions/widths (MODE bit 0, REPS [15:8])
  - the state enum {IDLE, UP, DOWN}
  - the STATUS bit positions.
- Sub-module walker_step_timer (DIVW-bit down-counter with load/start inputs and a one-cycle step output) is natural.
- Bus decode and the walk FSM stay in the top level.

Test Plan:
- NLEDS=8, DIV=0, CTRL=0x0001 (bounce, REPS=0): o_led walks 01,02,..,80,40,..,01, one per cycle. busy lasts 15 cycles, then o_led=0. ack arrives 1 cycle after the write.
- DIV=2, CTRL=0x0000 (one-way, REPS=0): each LED is held 3 cycles. 8 positions, 24 busy cycles, no repeat of 01.
- CTRL=0x0201 (bounce, REPS=2), DIV=0: 43 positions. STATUS read mid-walk shows busy=1 and passes remaining decrementing 2→1→0. Reads are never stalled.
- CTRL write while busy: o_stall=1 and stb is held until IDLE. It is accepted on the first idle cycle and the walk restarts at pos 0. No ack is issued while stalled.
- DIV write from 0 to 5 mid-walk: the current position finishes at the old rate; subsequent positions are held 6 cycles.
- Assert i_reset_n=0 mid-walk, off-edge: o_led=0 and o_busy=0 at once. After release, DIV=0 and the next CTRL write starts normally. With WALKER_ABORT_EN, an address-3 write mid-walk gives o_led=0 the next cycle.
